// File: rtl/divmod_unpack_pkg.sv
// Shared types and widths for the divmod_unpack divider.
//   P       operand width; the dividend is 2P bits and the divisor is P bits
//   QW      dividend/quotient width (2P)
//   CW      step counter width ($clog2(2P))
// Optional feature macro used by the top: DIVMOD_OUTREG_EN (one-entry output register).
package divmod_unpack_pkg;

    localparam int unsigned P  = 8;
    localparam int unsigned QW = 2 * P;
    localparam int unsigned CW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} divmod_state_t;

    typedef struct packed {
        logic [QW-1:0] q;
        logic [P-1:0]  r;
        logic          ovf;
        logic          dz;
    } divmod_res_t;

endpackage

// File: rtl/divmod_unpack_step.sv
// One restoring division step: shift in the next dividend bit, subtract the
// divisor when it fits.
//   rem      in   P+1  partial remainder (always < div, so rem[P] is 0 on entry)
//   div      in   P    divisor
//   in_bit   in   1    next dividend bit, MSB first
//   rem_nxt  out  P+1  updated partial remainder
//   q_bit    out  1    quotient bit produced by this step
module divmod_unpack_step
    import divmod_unpack_pkg::*;
(
    input  logic [P:0]   rem,
    input  logic [P-1:0] div,
    input  logic         in_bit,
    output logic [P:0]   rem_nxt,
    output logic         q_bit
);

    logic [P:0] shifted;
    logic [P:0] divExt;

    // The shifted value can reach 2*div-1, hence the extra remainder bit.
    always_comb begin
        shifted = {rem[P-1:0], in_bit};
        divExt  = {1'b0, div};
        q_bit   = (shifted >= divExt);
        rem_nxt = q_bit ? (shifted - divExt) : shifted;
    end

endmodule

// File: rtl/divmod_unpack.sv
// Iterative restoring divider: splits a 2P-bit word by a P-bit divisor into a
// 2P-bit quotient and P-bit remainder, one quotient bit per clock, with
// valid/ready handshakes on both sides.
//   C          clock (posedge)
//   RST_N      synchronous active-low reset
//   IN_VALID   / IN_READY    input handshake; DATA_IN dividend, DIV_IN divisor
//   OUT_VALID  / OUT_READY   output handshake; Q_OUT, R_OUT, OVF, DZ result
// DIVMOD_OUTREG_EN: adds a one-entry output register so a new divide can run
// while a finished result waits downstream.
module divmod_unpack
    import divmod_unpack_pkg::*;
(
    input  logic          C,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [QW-1:0] DATA_IN,
    input  logic [P-1:0]  DIV_IN,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [QW-1:0] Q_OUT,
    output logic [P-1:0]  R_OUT,
    output logic          OVF,
    output logic          DZ
);

    divmod_state_t state, stateNxt;
    logic [CW-1:0] cnt, cntNxt;
    logic [QW-1:0] work, workNxt;   // dividend bits shift out, quotient bits shift in
    logic [P:0]    rem, remNxt;
    logic [P-1:0]  div, divNxt;
    divmod_res_t   res, resNxt;
    divmod_res_t   finRes;
    logic          finish;
    logic          inReadyQ;
    logic [P:0]    stepRem;
    logic          stepQ;

`ifdef DIVMOD_OUTREG_EN
    divmod_res_t outRes, outResNxt;
    logic        outFull, outFullNxt;
    logic        outFree;
    logic        outLoad;
`else
    logic        outValidQ;
`endif

    divmod_unpack_step uStep (
        .rem     (rem),
        .div     (div),
        .in_bit  (work[QW-1]),
        .rem_nxt (stepRem),
        .q_bit   (stepQ)
    );

    // Next-state and datapath update.
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        workNxt  = work;
        remNxt   = rem;
        divNxt   = div;
        resNxt   = res;
        finish   = 1'b0;
        finRes   = '0;
`ifdef DIVMOD_OUTREG_EN
        outFree    = !outFull || OUT_READY;
        outLoad    = 1'b0;
        outResNxt  = outRes;
`endif

        unique case (state)
            IDLE: begin
                if (IN_VALID && inReadyQ) begin
                    workNxt = DATA_IN;
                    divNxt  = DIV_IN;
                    remNxt  = '0;
                    cntNxt  = CW'(QW - 1);
                    if (DIV_IN == '0) begin
                        finish     = 1'b1;
                        finRes.q   = '1;
                        finRes.r   = DATA_IN[P-1:0];
                        finRes.ovf = 1'b0;
                        finRes.dz  = 1'b1;
                    end else begin
                        stateNxt = BUSY;
                    end
                end
            end
            BUSY: begin
                workNxt = {work[QW-2:0], stepQ};
                remNxt  = stepRem;
                if (cnt == '0) begin
                    finish     = 1'b1;
                    finRes.q   = {work[QW-2:0], stepQ};
                    finRes.r   = stepRem[P-1:0];
                    finRes.ovf = |work[QW-2:P-1];   // upper half of the final quotient
                    finRes.dz  = 1'b0;
                end else begin
                    cntNxt = cnt - CW'(1);
                end
            end
            DONE: begin
            end
            default: stateNxt = IDLE;
        endcase

        if (finish) begin
            resNxt = finRes;
        end

`ifdef DIVMOD_OUTREG_EN
        // A finished result bypasses DONE whenever the output slot is free or draining.
        if (finish) begin
            if (outFree) begin
                outLoad   = 1'b1;
                outResNxt = finRes;
                stateNxt  = IDLE;
            end else begin
                stateNxt  = DONE;
            end
        end
        if (state == DONE && outFree) begin
            outLoad   = 1'b1;
            outResNxt = res;
            stateNxt  = IDLE;
        end
        outFullNxt = outLoad ? 1'b1 : (OUT_READY ? 1'b0 : outFull);
`else
        if (finish) begin
            stateNxt = DONE;
        end
        if (state == DONE && OUT_READY) begin
            stateNxt = IDLE;
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge C) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            rem      <= '0;
            div      <= '0;
            res      <= '0;
            inReadyQ <= 1'b1;
`ifdef DIVMOD_OUTREG_EN
            outRes   <= '0;
            outFull  <= 1'b0;
`else
            outValidQ <= 1'b0;
`endif
        end else begin
            state    <= stateNxt;
            cnt      <= cntNxt;
            work     <= workNxt;
            rem      <= remNxt;
            div      <= divNxt;
            res      <= resNxt;
            inReadyQ <= (stateNxt == IDLE);
`ifdef DIVMOD_OUTREG_EN
            outRes   <= outResNxt;
            outFull  <= outFullNxt;
`else
            outValidQ <= (stateNxt == DONE);
`endif
        end
    end

    assign IN_READY = inReadyQ;
`ifdef DIVMOD_OUTREG_EN
    assign OUT_VALID = outFull;
    assign Q_OUT     = outRes.q;
    assign R_OUT     = outRes.r;
    assign OVF       = outRes.ovf;
    assign DZ        = outRes.dz;
`else
    assign OUT_VALID = outValidQ;
    assign Q_OUT     = res.q;
    assign R_OUT     = res.r;
    assign OVF       = res.ovf;
    assign DZ        = res.dz;
`endif

endmodule

// File: tb/tb_divmod_unpack.sv
// Directed self-checking bench for divmod_unpack (P=8).
module tb_divmod_unpack;

    logic        C = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] DATA_IN;
    logic [7:0]  DIV_IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] Q_OUT;
    logic [7:0]  R_OUT;
    logic        OVF;
    logic        DZ;

    int total = 0;
    int bad   = 0;
    int lat;

    divmod_unpack dut (
        .C         (C),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .DATA_IN   (DATA_IN),
        .DIV_IN    (DIV_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Q_OUT     (Q_OUT),
        .R_OUT     (R_OUT),
        .OVF       (OVF),
        .DZ        (DZ)
    );

    always #5 C = ~C;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single accept edge.
    task automatic issue(input logic [15:0] d, input logic [7:0] v);
        chk("in_ready_before_issue", 32'(IN_READY), 32'd1);
        IN_VALID = 1'b1;
        DATA_IN  = d;
        DIV_IN   = v;
        tick();
        IN_VALID = 1'b0;
    endtask

    // Edges from the accept edge until OUT_VALID, bounded.
    task automatic waitValid(output int n);
        n = 0;
        while (!OUT_VALID && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic chkRes(input string tag, input logic [15:0] q, input logic [7:0] r,
                          input logic ovf, input logic dz);
        chk({tag, "_q"},   32'(Q_OUT), 32'(q));
        chk({tag, "_r"},   32'(R_OUT), 32'(r));
        chk({tag, "_ovf"}, 32'(OVF),   32'(ovf));
        chk({tag, "_dz"},  32'(DZ),    32'(dz));
    endtask

    task automatic drain(input string tag);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk({tag, "_drained"}, 32'(OUT_VALID), 32'd0);
    endtask

    initial begin
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        DATA_IN   = '0;
        DIV_IN    = '0;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_in_ready",  32'(IN_READY),  32'd1);
        chkRes("rst", 16'h0000, 8'h00, 1'b0, 1'b0);
        RST_N = 1'b1;
        tick();

        // 1: 200*13+7
        issue(16'h0A2F, 8'd13);
        waitValid(lat);
        chk("t1_latency", 32'(lat), 32'd16);
        chkRes("t1", 16'h00C8, 8'd7, 1'b0, 1'b0);
        drain("t1");

        // 2: divide by zero, one edge
        issue(16'h1234, 8'd0);
        waitValid(lat);
        chk("t2_latency", 32'(lat), 32'd0);
        chkRes("t2", 16'hFFFF, 8'h34, 1'b0, 1'b1);
        drain("t2");

        // 3: overflow cases
        issue(16'hFFFF, 8'd1);
        waitValid(lat);
        chk("t3a_latency", 32'(lat), 32'd16);
        chkRes("t3a", 16'hFFFF, 8'h00, 1'b1, 1'b0);
        drain("t3a");
        issue(16'hFFFF, 8'hFF);
        waitValid(lat);
        chkRes("t3b", 16'h0101, 8'h00, 1'b1, 1'b0);
        drain("t3b");

        // Extra patterns: 4660/86 = 54 r 16; remainder just under divisor
        issue(16'h1234, 8'h56);
        waitValid(lat);
        chkRes("t3c", 16'h0036, 8'h10, 1'b0, 1'b0);
        drain("t3c");
        issue(16'h00FE, 8'hFF);
        waitValid(lat);
        chkRes("t3d", 16'h0000, 8'hFE, 1'b0, 1'b0);
        drain("t3d");

        // 4: downstream stall for 5 cycles
        issue(16'h0A2F, 8'd13);
        waitValid(lat);
        chk("t4_latency", 32'(lat), 32'd16);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 32'(OUT_VALID), 32'd1);
            chkRes("t4_hold", 16'h00C8, 8'd7, 1'b0, 1'b0);
`ifdef DIVMOD_OUTREG_EN
            chk("t4_in_ready", 32'(IN_READY), 32'd1);
`else
            chk("t4_in_ready", 32'(IN_READY), 32'd0);
`endif
        end
        drain("t4");
        tick();
        chk("t4_single_transfer", 32'(OUT_VALID), 32'd0);

        // 5: reset on the 7th BUSY edge aborts the operation
        issue(16'h0A2F, 8'd13);
        for (int i = 0; i < 6; i++) tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("t5_out_valid", 32'(OUT_VALID), 32'd0);
        chk("t5_in_ready",  32'(IN_READY),  32'd1);
        chkRes("t5_rst", 16'h0000, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_no_result", 32'(OUT_VALID), 32'd0);
        issue(16'h0064, 8'd10);
        waitValid(lat);
        chk("t5_latency", 32'(lat), 32'd16);
        chkRes("t5_new", 16'h000A, 8'h00, 1'b0, 1'b0);
        drain("t5");

`ifdef DIVMOD_OUTREG_EN
        // 6: second divide overlaps a stalled result; results leave in order
        issue(16'h0A2F, 8'd13);
        waitValid(lat);
        chk("t6_op1_latency", 32'(lat), 32'd16);
        chk("t6_in_ready_op1", 32'(IN_READY), 32'd1);
        issue(16'h0064, 8'd10);
        for (int i = 0; i < 17; i++) tick();
        chk("t6_in_ready_held", 32'(IN_READY), 32'd0);
        chk("t6_valid_op1", 32'(OUT_VALID), 32'd1);
        chkRes("t6_op1", 16'h00C8, 8'd7, 1'b0, 1'b0);
        OUT_READY = 1'b1;
        tick();
        chk("t6_valid_op2", 32'(OUT_VALID), 32'd1);
        chkRes("t6_op2", 16'h000A, 8'h00, 1'b0, 1'b0);
        chk("t6_in_ready_after", 32'(IN_READY), 32'd1);
        tick();
        OUT_READY = 1'b0;
        chk("t6_drained", 32'(OUT_VALID), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
